// File: rtl/edge_capture_bank_if.sv
// edge_capture_bank_if: enable, trigger, data, clear and read-back bundle for edge_capture_bank
interface edge_capture_bank_if #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 4
);
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic                 en;
  logic [CHANNELS-1:0]  trig;
  logic [WIDTH-1:0]     d;
  logic [CHANNELS-1:0]  clr;
  logic [SEL_W-1:0]     sel;
  logic [CHANNELS-1:0]  pulse;
  logic [CHANNELS-1:0]  flag;
  logic [CHANNELS-1:0]  ovf;
  logic [WIDTH-1:0]     q;
  logic [CNT_WIDTH-1:0] cnt;
  modport master (output en, trig, d, clr, sel, input pulse, flag, ovf, q, cnt);
  modport slave  (input en, trig, d, clr, sel, output pulse, flag, ovf, q, cnt);
endinterface

// File: rtl/edge_capture_bank.sv
// edge_capture_bank: synchronized per-channel edge detect with data capture, sticky flags and saturating counters
module edge_capture_bank #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input logic clk,
  input logic reset,
  edge_capture_bank_if.slave bus
);
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0] hist_q, hist_d, pulse_q, pulse_d, flag_q, flag_d, ovf_q, ovf_d;
  logic [CHANNELS-1:0] rise, fall, ev;
  logic [CHANNELS-1:0][WIDTH-1:0] cap_q, cap_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  // An event coinciding with a clear wins: it restarts the channel at count 1.
  always_comb begin
    sync_d[0] = bus.trig;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    hist_d = sync_q[SYNC_STAGES-1];
    rise = hist_d & ~hist_q;
    fall = ~hist_d & hist_q;
    ev = (EDGE_MODE == 0 ? rise : EDGE_MODE == 1 ? fall : rise | fall) & {CHANNELS{bus.en}};
    pulse_d = ev;
    for (int c = 0; c < CHANNELS; c++) begin
      flag_d[c] = ev[c] | (flag_q[c] & ~bus.clr[c]);
      cap_d[c] = ev[c] ? bus.d : cap_q[c];
      cnt_d[c] = ev[c] ? (bus.clr[c] ? CNT_WIDTH'(1) : cnt_q[c] == CNT_MAX ? cnt_q[c] : cnt_q[c] + 1'b1)
                       : (bus.clr[c] ? '0 : cnt_q[c]);
      ovf_d[c] = ~bus.clr[c] & (ovf_q[c] | (ev[c] & cnt_q[c] == CNT_MAX));
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      ovf_q   <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    bus.q = '0;
    bus.cnt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.sel == SEL_W'(c)) begin
        bus.q = cap_q[c];
        bus.cnt = cnt_q[c];
      end
    end
  end
  assign bus.pulse = pulse_q;
  assign bus.flag  = flag_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: doc/edge_capture_bank.md
EDGE_CAPTURE_BANK -- requirements
Module: edge_capture_bank

Interface
REQ-001 Parameter WIDTH, default 8: width of captured data word D/Q, legal range 1..32.
REQ-002 Parameter CHANNELS, default 4: number of independent trigger channels, legal range 1..16.
REQ-003 Parameter EDGE_MODE, default 0: 0 = rising, 1 = falling, 2 = both edges; applies to all channels.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth per trigger, legal range 1..3.
REQ-005 Parameter CNT_WIDTH, default 4: per-channel event counter width, legal range 1..8.
REQ-006 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-007 RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-008 EN  input  1  global detect enable.
REQ-009 TRIG  input  CHANNELS  asynchronous trigger lines, one per channel.
REQ-010 D  input  WIDTH  data word captured on a channel event.
REQ-011 CLR  input  CHANNELS  per-channel synchronous clear of FLAG/counter/OVF.
REQ-012 SEL  input  max(1,clog2(CHANNELS))  read-back channel select.
REQ-013 PULSE  output  CHANNELS  one-cycle registered event strobe per channel.
REQ-014 FLAG  output  CHANNELS  sticky event flag per channel.
REQ-015 OVF  output  CHANNELS  sticky counter-overflow flag per channel.
REQ-016 Q  output  WIDTH  captured word of channel SEL.
REQ-017 CNT  output  CNT_WIDTH  event count of channel SEL.

Function
REQ-018 Each TRIG bit shall pass through SYNC_STAGES flops, then one history flop; event_i = edge between sync output and history per EDGE_MODE.
REQ-019 Synchronizer and history flops shall shift every cycle regardless of EN, so re-enabling never produces a false event.
REQ-020 Latency: TRIG change first sampled at edge k -> PULSE[i], FLAG[i], capture, and counter update all take effect at edge k+SYNC_STAGES (visible after that edge).
REQ-021 PULSE[i] shall be high exactly one cycle per event; consecutive events on consecutive cycles (EDGE_MODE=2, toggling TRIG) give PULSE high on each.
REQ-022 On event with EN=1: capture register i <= D sampled at that same edge; FLAG[i] <= 1; counter i increments by 1.
REQ-023 With EN=0: PULSE=0, no capture, no FLAG/counter/OVF change.
REQ-024 Counter saturates at 2^CNT_WIDTH-1; an event while saturated keeps the count, sets OVF[i], and still captures D.
REQ-025 CLR[i] alone: FLAG[i]=0, counter i=0, OVF[i]=0; capture register i retained.
REQ-026 CLR[i] and event in the same cycle: event wins -- FLAG[i]=1, counter i=1, OVF[i]=0, D captured, PULSE[i]=1.
REQ-027 Channels are fully independent; simultaneous events on several channels all update in the same cycle.
REQ-028 Q and CNT are combinational muxes of channel SEL registers (zero-cycle read); SEL >= CHANNELS yields Q=0, CNT=0.

Reset
REQ-029 RESET=1 at an edge clears every flop: sync chain, history, PULSE, FLAG, OVF, counters, capture registers; Q=0, CNT=0 after that edge.
REQ-030 RESET overrides EN, CLR and any event in the same cycle.
REQ-031 RESET asserted mid-operation discards in-flight sync-chain events; no PULSE in the cycle after RESET.
REQ-032 TRIG held high through reset with EDGE_MODE=0 or 2 shall yield exactly one event SYNC_STAGES+1 edges after RESET deasserts (history starts at 0).

Verification
REQ-033 Defaults, EN=1, D=0xA5, TRIG[1] 0->1 sampled at edge 10 -> PULSE[1]=1 only after edge 12, FLAG[1]=1, SEL=1 reads Q=0xA5, CNT=1; other channels unchanged.
REQ-034 CNT_WIDTH=2, 4 rising events on ch0 -> CNT=3, OVF[0]=1 after 4th event; CLR[0] pulse -> CNT=0, FLAG[0]=0, OVF[0]=0, Q kept.
REQ-035 EN=0 during an edge, then EN=1 with TRIG static -> no PULSE, FLAG stays 0.
REQ-036 EDGE_MODE=2, TRIG[2] toggled every cycle for 3 cycles -> 3 consecutive PULSE[2] cycles, CNT=3.
REQ-037 CLR[3] coincident with event on ch3, D=0x3C -> FLAG[3]=1, CNT=1, Q=0x3C; RESET coincident with event -> all outputs 0, no later PULSE.
REQ-038 SEL=CHANNELS (out of range, CHANNELS=4 -> use CHANNELS=5 build with SEL=7) -> Q=0, CNT=0.
